// File: rtl/exe_fwd_hzd_unit_pkg.sv
// Shared constants for the EXE stage: ALU commands, shift types, forward selects, NZCV indices.
// Optional STALL_CNT_EN build adds a hazard stall counter to the top.
package exe_fwd_hzd_unit_pkg;

   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;

   typedef enum logic [1:0] {
      SH_LSL = 2'b00,
      SH_LSR = 2'b01,
      SH_ASR = 2'b10,
      SH_ROR = 2'b11
   } shift_t;

   typedef enum logic [1:0] {
      SEL_REG = 2'b00,
      SEL_MEM = 2'b01,
      SEL_WB  = 2'b10
   } fwd_sel_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] n);
      logic [63:0] d;
      d = {v, v} >> n;
      return d[31:0];
   endfunction

endpackage

// File: rtl/exe_fwd_hzd_unit_if.sv
// Bus between the ID/EXE register, the EXE stage and the MEM stage.
// Valid/ready semantics: none -- every field is qualified by freeze (hold) and the per-stage enables.
interface exe_fwd_hzd_unit_if;

   logic        freeze;
   logic        fwrd_en;
   logic [31:0] pc;
   logic [31:0] rn_val;
   logic [31:0] rm_val;
   logic [31:0] val_wb;
   logic [23:0] signed_imm_24;
   logic [11:0] shifter_operand;
   logic [3:0]  exe_cmd;
   logic [3:0]  dest;
   logic [3:0]  status_in;
   logic        wb_en;
   logic        mem_r_en;
   logic        mem_w_en;
   logic        b;
   logic        s;
   logic        imm;
   logic [3:0]  src1_exe;
   logic [3:0]  src2_exe;
   logic [3:0]  id_src1;
   logic [3:0]  id_src2;
   logic        id_two_src;
   logic        id_move;
   logic        wb_en_wb;
   logic [3:0]  dest_wb;

   logic [31:0] branch_address;
   logic [3:0]  status_out;
   logic [31:0] alu_res_mem;
   logic [31:0] rm_val_mem;
   logic [3:0]  dest_mem;
   logic        wb_en_mem;
   logic        mem_r_en_mem;
   logic        mem_w_en_mem;
   logic        hazard;
   logic [1:0]  fwd_sel1;
   logic [1:0]  fwd_sel2;

   modport slave (
      input  freeze, fwrd_en, pc, rn_val, rm_val, val_wb, signed_imm_24, shifter_operand,
             exe_cmd, dest, status_in, wb_en, mem_r_en, mem_w_en, b, s, imm,
             src1_exe, src2_exe, id_src1, id_src2, id_two_src, id_move, wb_en_wb, dest_wb,
      output branch_address, status_out, alu_res_mem, rm_val_mem, dest_mem,
             wb_en_mem, mem_r_en_mem, mem_w_en_mem, hazard, fwd_sel1, fwd_sel2
   );

   modport master (
      output freeze, fwrd_en, pc, rn_val, rm_val, val_wb, signed_imm_24, shifter_operand,
             exe_cmd, dest, status_in, wb_en, mem_r_en, mem_w_en, b, s, imm,
             src1_exe, src2_exe, id_src1, id_src2, id_two_src, id_move, wb_en_wb, dest_wb,
      input  branch_address, status_out, alu_res_mem, rm_val_mem, dest_mem,
             wb_en_mem, mem_r_en_mem, mem_w_en_mem, hazard, fwd_sel1, fwd_sel2
   );

endinterface

// File: rtl/exe_fwd_hzd_unit_val2_gen.sv
// Operand-2 generator: memory offset, rotated 8-bit immediate, or shifted register.
module exe_fwd_hzd_unit_val2_gen
   import exe_fwd_hzd_unit_pkg::*;
(
   input  logic [31:0] rm_i,
   input  logic [11:0] so_i,
   input  logic        imm_i,
   input  logic        mem_i,
   output logic [31:0] val2_o
);

   logic [4:0]  amt;
   shift_t      sh_type;
   logic [31:0] shifted;

   assign amt     = so_i[11:7];
   assign sh_type = shift_t'(so_i[6:5]);

   // A zero amount falls out of every shift form as a pass-through.
   always_comb begin
      shifted = rm_i;
      case (sh_type)
         SH_LSL:  shifted = rm_i << amt;
         SH_LSR:  shifted = rm_i >> amt;
         SH_ASR:  shifted = 32'($signed(rm_i) >>> amt);
         SH_ROR:  shifted = ror32(rm_i, amt);
         default: shifted = rm_i;
      endcase
   end

   always_comb begin
      if (mem_i) begin
         val2_o = {20'b0, so_i};
      end else if (imm_i) begin
         val2_o = ror32({24'b0, so_i[7:0]}, {so_i[11:8], 1'b0});
      end else begin
         val2_o = shifted;
      end
   end

endmodule

// File: rtl/exe_fwd_hzd_unit.sv
// ARM32 execute stage: forwarding, ALU/flags, branch target, EXE/MEM and status registers, hazard detect.
// Define STALL_CNT_EN to add the saturating stall_count output.
module exe_fwd_hzd_unit
   import exe_fwd_hzd_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input logic clk,
   input logic rst,
   exe_fwd_hzd_unit_if.slave bus
`ifdef STALL_CNT_EN
   ,
   output logic [31:0] stall_count
`endif
);

   logic [XLEN-1:0] alu_res_q, alu_res_d;
   logic [XLEN-1:0] rm_val_q;
   logic [3:0]      dest_q;
   logic            wb_en_q, mem_r_en_q, mem_w_en_q;
   logic [3:0]      status_q, status_d;

   fwd_sel_t        sel1, sel2;
   logic [XLEN-1:0] op_a, rm_fwd, val2, b_op;
   logic [XLEN:0]   sum;
   logic            cin, c_in, is_arith;
   logic            hd, r1, r2;
   logic            unused_b;

   assign unused_b = bus.b;
   assign c_in     = bus.status_in[FLAG_C];

   // MEM-stage result is younger than WB, so it wins when both match.
   always_comb begin
      sel1 = SEL_REG;
      if (bus.fwrd_en && wb_en_q && bus.src1_exe == dest_q) sel1 = SEL_MEM;
      else if (bus.fwrd_en && bus.wb_en_wb && bus.src1_exe == bus.dest_wb) sel1 = SEL_WB;
      sel2 = SEL_REG;
      if (bus.fwrd_en && wb_en_q && bus.src2_exe == dest_q) sel2 = SEL_MEM;
      else if (bus.fwrd_en && bus.wb_en_wb && bus.src2_exe == bus.dest_wb) sel2 = SEL_WB;
   end

   always_comb begin
      case (sel1)
         SEL_MEM: op_a = alu_res_q;
         SEL_WB:  op_a = bus.val_wb;
         default: op_a = bus.rn_val;
      endcase
      case (sel2)
         SEL_MEM: rm_fwd = alu_res_q;
         SEL_WB:  rm_fwd = bus.val_wb;
         default: rm_fwd = bus.rm_val;
      endcase
   end

   exe_fwd_hzd_unit_val2_gen u_val2_gen (
      .rm_i   (rm_fwd),
      .so_i   (bus.shifter_operand),
      .imm_i  (bus.imm),
      .mem_i  (bus.mem_r_en | bus.mem_w_en),
      .val2_o (val2)
   );

   // Subtraction reuses the adder as A + ~B + cin so C comes out as NOT-borrow.
   always_comb begin
      b_op     = val2;
      cin      = 1'b0;
      is_arith = 1'b0;
      case (bus.exe_cmd)
         CMD_ADD: is_arith = 1'b1;
         CMD_ADC: begin is_arith = 1'b1; cin = c_in; end
         CMD_SUB: begin is_arith = 1'b1; b_op = ~val2; cin = 1'b1; end
         CMD_SBC: begin is_arith = 1'b1; b_op = ~val2; cin = c_in; end
         default: ;
      endcase
   end

   assign sum = {1'b0, op_a} + {1'b0, b_op} + {{XLEN{1'b0}}, cin};

   always_comb begin
      case (bus.exe_cmd)
         CMD_MOV: alu_res_d = val2;
         CMD_MVN: alu_res_d = ~val2;
         CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: alu_res_d = sum[XLEN-1:0];
         CMD_AND: alu_res_d = op_a & val2;
         CMD_ORR: alu_res_d = op_a | val2;
         CMD_EOR: alu_res_d = op_a ^ val2;
         default: alu_res_d = '0;
      endcase
   end

   always_comb begin
      status_d         = bus.status_in;
      status_d[FLAG_N] = alu_res_d[XLEN-1];
      status_d[FLAG_Z] = (alu_res_d == '0);
      if (is_arith) begin
         status_d[FLAG_C] = sum[XLEN];
         status_d[FLAG_V] = (op_a[XLEN-1] == b_op[XLEN-1]) && (sum[XLEN-1] != op_a[XLEN-1]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_res_q  <= '0;
         rm_val_q   <= '0;
         dest_q     <= '0;
         wb_en_q    <= 1'b0;
         mem_r_en_q <= 1'b0;
         mem_w_en_q <= 1'b0;
         status_q   <= '0;
      end else if (!bus.freeze) begin
         alu_res_q  <= alu_res_d;
         rm_val_q   <= rm_fwd;
         dest_q     <= bus.dest;
         wb_en_q    <= bus.wb_en;
         mem_r_en_q <= bus.mem_r_en;
         mem_w_en_q <= bus.mem_w_en;
         if (bus.s) status_q <= status_d;
      end
   end

   // With forwarding on, only a load in EXE cannot be bypassed in time.
   always_comb begin
      hd = bus.fwrd_en & ~bus.mem_r_en;
      r1 = ~bus.id_move & ((bus.wb_en & (bus.id_src1 == bus.dest)) |
                           (wb_en_q & (bus.id_src1 == dest_q)));
      r2 = (bus.wb_en & (bus.id_src2 == bus.dest)) | (wb_en_q & (bus.id_src2 == dest_q));
   end

   assign bus.hazard         = ~hd & (r1 | (bus.id_two_src & r2));
   assign bus.branch_address = bus.pc + {{6{bus.signed_imm_24[23]}}, bus.signed_imm_24, 2'b00};
   assign bus.status_out     = status_q;
   assign bus.alu_res_mem    = alu_res_q;
   assign bus.rm_val_mem     = rm_val_q;
   assign bus.dest_mem       = dest_q;
   assign bus.wb_en_mem      = wb_en_q;
   assign bus.mem_r_en_mem   = mem_r_en_q;
   assign bus.mem_w_en_mem   = mem_w_en_q;
   assign bus.fwd_sel1       = sel1;
   assign bus.fwd_sel2       = sel2;

`ifdef STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else if (bus.hazard && !bus.freeze && stall_cnt_q != 32'hFFFF_FFFF) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_exe_fwd_hzd_unit.sv
// Self-checking bench for exe_fwd_hzd_unit: directed cases then random instructions vs a reference model.
module tb_exe_fwd_hzd_unit;
   import exe_fwd_hzd_unit_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   exe_fwd_hzd_unit_if bus ();
`ifdef STALL_CNT_EN
   logic [31:0] stall_count;
   exe_fwd_hzd_unit #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus), .stall_count(stall_count));
`else
   exe_fwd_hzd_unit #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference state of the EXE/MEM register, status register and stall count.
   logic [31:0] m_alu, m_rm;
   logic [3:0]  m_dest, m_status;
   logic        m_wb, m_r, m_w;
   logic [31:0] m_stalls;

   logic [31:0] e_alu, e_rmf, e_ba;
   logic [3:0]  e_nzcv;
   logic [1:0]  e_sel1, e_sel2;
   logic        e_hz;

   task automatic model_reset();
      m_alu = 0; m_rm = 0; m_dest = 0; m_status = 0;
      m_wb = 0; m_r = 0; m_w = 0; m_stalls = 0;
   endtask

   function automatic logic [1:0] pick_sel(input logic [3:0] src);
      if (bus.fwrd_en && m_wb && src == m_dest) return 2'd1;
      if (bus.fwrd_en && bus.wb_en_wb && src == bus.dest_wb) return 2'd2;
      return 2'd0;
   endfunction

   function automatic logic [31:0] rot_r(input logic [31:0] x, input int k);
      logic [63:0] w, lo, hi;
      w  = {32'b0, x};
      lo = w >> k;
      hi = w << (32 - k);
      return lo[31:0] | hi[31:0];
   endfunction

   function automatic logic in_range(input longint v);
      return (v <= 64'sd2147483647) && (v >= -64'sd2147483648);
   endfunction

   task automatic model_comb();
      logic [31:0] a, v2, res;
      logic [11:0] so;
      logic [63:0] u, x64;
      longint      sa, sv, sx, li;
      logic        cf, vf;
      int          amt;
      e_sel1 = pick_sel(bus.src1_exe);
      e_sel2 = pick_sel(bus.src2_exe);
      a      = (e_sel1 == 2'd1) ? m_alu : (e_sel1 == 2'd2) ? bus.val_wb : bus.rn_val;
      e_rmf  = (e_sel2 == 2'd1) ? m_alu : (e_sel2 == 2'd2) ? bus.val_wb : bus.rm_val;
      so = bus.shifter_operand;
      amt = int'(so[11:7]);
      x64 = {32'b0, e_rmf};
      if (bus.mem_r_en || bus.mem_w_en) v2 = {20'b0, so};
      else if (bus.imm) v2 = rot_r({24'b0, so[7:0]}, 2 * int'(so[11:8]));
      else begin
         case (so[6:5])
            2'b00: begin u = x64 << amt; v2 = u[31:0]; end
            2'b01: v2 = e_rmf >> amt;
            2'b10: begin sx = longint'($signed(e_rmf)); sx = sx >>> amt; v2 = sx[31:0]; end
            default: v2 = rot_r(e_rmf, amt);
         endcase
      end
      sa = longint'($signed(a));
      sv = longint'($signed(v2));
      cf = bus.status_in[1];
      vf = bus.status_in[0];
      case (bus.exe_cmd)
         4'b0001: res = v2;
         4'b1001: res = ~v2;
         4'b0010: begin u = 64'(a) + 64'(v2); res = u[31:0]; cf = u[32]; vf = !in_range(sa + sv); end
         4'b0011: begin
            u = 64'(a) + 64'(v2) + 64'(bus.status_in[1]); res = u[31:0]; cf = u[32];
            vf = !in_range(sa + sv + longint'(bus.status_in[1]));
         end
         4'b0100: begin
            u = 64'(a) + (64'hFFFF_FFFF - 64'(v2)) + 64'd1; res = u[31:0]; cf = u[32];
            vf = !in_range(sa - sv);
         end
         4'b0101: begin
            u = 64'(a) + (64'hFFFF_FFFF - 64'(v2)) + 64'(bus.status_in[1]); res = u[31:0]; cf = u[32];
            vf = !in_range(sa - sv - 1 + longint'(bus.status_in[1]));
         end
         4'b0110: res = a & v2;
         4'b0111: res = a | v2;
         4'b1000: res = a ^ v2;
         default: res = 0;
      endcase
      e_alu  = res;
      e_nzcv = {res[31], res == 0, cf, vf};
      li = longint'($signed(bus.signed_imm_24));
      u = 64'(bus.pc) + 64'(li * 4);
      e_ba = u[31:0];
      // A stall is needed when the ID instruction reads a register EXE or MEM will write and no bypass can cover it.
      e_hz = !(bus.fwrd_en && !bus.mem_r_en) &&
             ((!bus.id_move && ((bus.wb_en && bus.id_src1 == bus.dest) || (m_wb && bus.id_src1 == m_dest))) ||
              (bus.id_two_src && ((bus.wb_en && bus.id_src2 == bus.dest) || (m_wb && bus.id_src2 == m_dest))));
   endtask

   task automatic check_regs(input string tag);
      check({tag, "/alu_res_mem"}, bus.alu_res_mem, m_alu);
      check({tag, "/rm_val_mem"}, bus.rm_val_mem, m_rm);
      check({tag, "/ctl_mem"}, 32'({bus.dest_mem, bus.wb_en_mem, bus.mem_r_en_mem, bus.mem_w_en_mem}),
            32'({m_dest, m_wb, m_r, m_w}));
      check({tag, "/status"}, 32'(bus.status_out), 32'(m_status));
`ifdef STALL_CNT_EN
      check({tag, "/stall_count"}, stall_count, m_stalls);
`endif
   endtask

   // Called just after a falling edge with inputs applied; returns at the next falling edge.
   task automatic step(input string tag);
      model_comb();
      #1;
      check({tag, "/hazard"}, 32'(bus.hazard), 32'(e_hz));
      check({tag, "/branch"}, bus.branch_address, e_ba);
      check({tag, "/sel1"}, 32'(bus.fwd_sel1), 32'(e_sel1));
      check({tag, "/sel2"}, 32'(bus.fwd_sel2), 32'(e_sel2));
      @(posedge clk);
      if (!bus.freeze) begin
         m_alu = e_alu; m_rm = e_rmf; m_dest = bus.dest;
         m_wb = bus.wb_en; m_r = bus.mem_r_en; m_w = bus.mem_w_en;
         if (bus.s) m_status = e_nzcv;
         if (e_hz && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
      end
      #1;
      check_regs(tag);
      @(negedge clk);
   endtask

   task automatic clear_in();
      bus.freeze = 0; bus.fwrd_en = 0; bus.pc = 0; bus.rn_val = 0; bus.rm_val = 0; bus.val_wb = 0;
      bus.signed_imm_24 = 0; bus.shifter_operand = 0; bus.exe_cmd = 0; bus.dest = 0; bus.status_in = 0;
      bus.wb_en = 0; bus.mem_r_en = 0; bus.mem_w_en = 0; bus.b = 0; bus.s = 0; bus.imm = 0;
      bus.src1_exe = 0; bus.src2_exe = 0; bus.id_src1 = 0; bus.id_src2 = 0;
      bus.id_two_src = 0; bus.id_move = 0; bus.wb_en_wb = 0; bus.dest_wb = 0;
   endtask

   initial begin
      rst = 1'b1;
      clear_in();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_regs("reset");
      @(negedge clk);
      rst = 1'b0;

      // Rotated immediate: 0x01 ror 4 = 0x10000000.
      bus.exe_cmd = CMD_ADD; bus.imm = 1; bus.shifter_operand = 12'h201; bus.rn_val = 5;
      step("add_imm");
      check("add_imm/const", bus.alu_res_mem, 32'h1000_0005);

      clear_in();
      bus.exe_cmd = CMD_SUB; bus.s = 1; bus.rn_val = 3; bus.rm_val = 3;
      step("sub_eq");
      check("sub_eq/const", 32'({bus.alu_res_mem, bus.status_out}), 32'({32'h0, 4'b0110}));

      clear_in();
      bus.exe_cmd = CMD_ADD; bus.s = 1; bus.imm = 1; bus.shifter_operand = 12'h001; bus.rn_val = 32'h7FFF_FFFF;
      step("add_ovf");
      check("add_ovf/const", 32'(bus.status_out), 32'(4'b1001));

      // Leave 0x55 in EXE/MEM targeting r2, then forward it.
      clear_in();
      bus.exe_cmd = CMD_MOV; bus.imm = 1; bus.shifter_operand = 12'h055; bus.wb_en = 1; bus.dest = 2;
      step("fwd_setup");
      clear_in();
      bus.exe_cmd = CMD_ADD; bus.fwrd_en = 1; bus.src1_exe = 2; bus.rn_val = 32'h1111;
      bus.wb_en_wb = 1; bus.dest_wb = 2; bus.val_wb = 32'h2222;
      step("fwd_mem");
      check("fwd_mem/const", bus.alu_res_mem, 32'h55);
      bus.fwrd_en = 0;
      step("fwd_off");
      check("fwd_off/const", bus.alu_res_mem, 32'h1111);

      // Hazard cases under freeze so the EXE/MEM register stays put between them.
      clear_in();
      bus.freeze = 1; bus.wb_en = 1; bus.dest = 3; bus.id_src1 = 9; bus.id_src2 = 3; bus.id_two_src = 1;
      step("hz_two_src");
      check("hz_two_src/const", 32'(bus.hazard), 32'd1);
      bus.id_two_src = 0;
      step("hz_one_src");
      check("hz_one_src/const", 32'(bus.hazard), 32'd0);
      bus.id_two_src = 1; bus.fwrd_en = 1;
      step("hz_fwd");
      check("hz_fwd/const", 32'(bus.hazard), 32'd0);
      bus.mem_r_en = 1;
      step("hz_load");
      check("hz_load/const", 32'(bus.hazard), 32'd1);
      bus.fwrd_en = 0; bus.mem_r_en = 0; bus.id_two_src = 0; bus.id_src1 = 3; bus.id_move = 1;
      step("hz_move");
      check("hz_move/const", 32'(bus.hazard), 32'd0);
      bus.id_move = 0;
      step("hz_src1");
      check("hz_src1/const", 32'(bus.hazard), 32'd1);

      clear_in();
      bus.pc = 32'h100; bus.signed_imm_24 = 24'hFFFFFE;
      step("branch");
      check("branch/const", bus.branch_address, 32'hF8);

      // Freeze holds the last result and flags.
      clear_in();
      bus.exe_cmd = CMD_MOV; bus.imm = 1; bus.shifter_operand = 12'h0AB; bus.s = 1; bus.status_in = 4'b0011;
      step("pre_freeze");
      bus.freeze = 1; bus.exe_cmd = CMD_ADD; bus.rn_val = 7; bus.status_in = 4'b0000;
      for (int i = 0; i < 3; i++) step("freeze");
      check("freeze/const", 32'({bus.alu_res_mem[11:0], bus.status_out}), 32'({12'h0AB, 4'b0011}));
      #1;
      rst = 1'b1;
      model_reset();
      #1;
      check_regs("rst_in_freeze");
      @(negedge clk);
      rst = 1'b0;

      for (int n = 0; n < 400; n++) begin
         clear_in();
         bus.freeze = ($urandom_range(0, 7) == 0);
         bus.fwrd_en = 1'($urandom_range(0, 1));
         bus.pc = $urandom;
         bus.rn_val = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
         bus.rm_val = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
         bus.val_wb = $urandom;
         bus.signed_imm_24 = 24'($urandom);
         bus.shifter_operand = 12'($urandom);
         bus.exe_cmd = 4'($urandom_range(0, 15));
         bus.dest = 4'($urandom_range(0, 3));
         bus.status_in = 4'($urandom_range(0, 15));
         bus.wb_en = 1'($urandom_range(0, 1));
         bus.mem_r_en = ($urandom_range(0, 3) == 0);
         bus.mem_w_en = ($urandom_range(0, 3) == 0);
         bus.b = 1'($urandom_range(0, 1));
         bus.s = 1'($urandom_range(0, 1));
         bus.imm = 1'($urandom_range(0, 1));
         bus.src1_exe = 4'($urandom_range(0, 3));
         bus.src2_exe = 4'($urandom_range(0, 3));
         bus.id_src1 = 4'($urandom_range(0, 3));
         bus.id_src2 = 4'($urandom_range(0, 3));
         bus.id_two_src = 1'($urandom_range(0, 1));
         bus.id_move = 1'($urandom_range(0, 1));
         bus.wb_en_wb = 1'($urandom_range(0, 1));
         bus.dest_wb = 4'($urandom_range(0, 3));
         step("rand");
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/exe_fwd_hzd_unit.md
Name: exe_fwd_hzd_unit

Overview:
Execute stage of the 5-stage ARM32 pipeline, with operand forwarding and load/RAW hazard detection built in. Sits between the ID/EXE register and the MEM stage. Computes the ALU result, branch target and NZCV flags, and holds the EXE/MEM pipeline register and the status register. Also produces the stall request for IF/ID and the forwarding selects.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, asynchronous, active-high
freeze  in  1  memory not ready; hold all state
fwrd_en  in  1  forwarding enable
pc  in  32  PC of the EXE instruction (already +4)
rn_val, rm_val  in  32  register-file operands
val_wb  in  32  writeback value
signed_imm_24  in  24  branch offset
shifter_operand  in  12  operand-2 field
exe_cmd  in  4  ALU command
dest  in  4  destination register
status_in  in  4  NZCV latched with the instruction
wb_en, mem_r_en, mem_w_en, b, s, imm  in  1  EXE control bits
src1_exe, src2_exe  in  4  source registers of the EXE instruction
id_src1, id_src2  in  4  source registers of the ID instruction
id_two_src, id_move  in  1  ID uses src2; ID is MOV/MVN (src1 unused)
wb_en_wb  in  1  WB-stage write enable
dest_wb  in  4  WB-stage destination
branch_address  out  32  branch target (combinational)
status_out  out  4  status register NZCV
alu_res_mem, rm_val_mem  out  32  EXE/MEM register
dest_mem  out  4  EXE/MEM register
wb_en_mem, mem_r_en_mem, mem_w_en_mem  out  1  EXE/MEM register
hazard  out  1  stall request (combinational)

Behaviour:
- Reset: all EXE/MEM outputs and the status register are 0.
- Forward select, per source: 01 (alu_res_mem) if fwrd_en & wb_en_mem & src==dest_mem; else 10 (val_wb) if fwrd_en & wb_en_wb & src==dest_wb; else 00 (register value). MEM beats WB.
- Operand A = forwarded rn. The forwarded rm feeds both val2 and rm_val_mem.
- val2:
  - If mem_r_en|mem_w_en: zero-extended shifter_operand[11:0].
  - Else if imm: {24'b0, so[7:0]} rotated right by 2*so[11:8].
  - Else: rm shifted by so[11:7] using type so[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR). A shift amount of 0 passes rm unchanged.
- exe_cmd:
  - 0001 MOV: val2
  - 1001 MVN: ~val2
  - 0010 ADD: A+val2
  - 0011 ADC: A+val2+C
  - 0100 SUB/CMP: A−val2
  - 0101 SBC: A+~val2+C
  - 0110 AND/TST, 0111 ORR, 1000 EOR
  - other: 0
- Flags:
  - N = res[31]; Z = res==0.
  - C = carry-out for ADD/ADC; NOT-borrow (carry of A+~B+cin) for SUB/SBC; otherwise held from status_in.
  - V = signed overflow for add/sub; otherwise held.
- C for ADC/SBC comes from status_in.
- Status register loads the new NZCV at posedge when s & ~freeze.
- branch_address = pc + (sign-extended imm24 << 2), mod 2^32.
- EXE/MEM register loads on every posedge when ~freeze; holds when freeze=1.
- Hazard disable hd = fwrd_en & ~mem_r_en.
- hazard = ~hd & (R1 | (id_two_src & R2)).
  - R1 = ~id_move & ((wb_en & id_src1==dest) | (wb_en_mem & id_src1==dest_mem)).
  - R2 is the same two comparisons on id_src2, without the id_move term.
- hazard is independent of freeze.

Optional Feature:
STALL_CNT_EN:
- Defined: adds output stall_count[31:0], which increments on each posedge with hazard=1 & ~freeze, saturates at 0xFFFFFFFF, and resets to 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: exe_cmd constants, shift-type codes, forward-select codes (SEL_REG=00, SEL_MEM=01, SEL_WB=10), NZCV bit indices.
- One sub-module: val2_gen (shifter/immediate rotator).
- ALU, forwarding and hazard logic stay inline.

Test Plan:
- ADD, imm=1, so=0x201, rn=5 -> alu_res_mem=0x10000005 after one clock.
- SUB, s=1, rn=3, rm=3 -> alu_res 0, status_out=0110 (Z=1, C=1).
- ADD, s=1, rn=0x7FFFFFFF, val2=1 -> N=1, V=1, C=0.
- Forwarding, fwrd_en=1, src1_exe=2:
  - dest_mem=2, wb_en_mem=1, dest_wb=2, wb_en_wb=1 -> A=alu_res_mem.
  - fwrd_en=0 -> A=rn_val.
- Hazard:
  - fwrd_en=0, wb_en=1, dest=3, id_src2=3 -> hazard=1 if id_two_src=1, 0 if id_two_src=0.
  - fwrd_en=1 -> 0, unless mem_r_en=1 -> 1.
  - id_move=1 with id_src1 match -> 0.
- Branch and freeze:
  - pc=0x100, imm24=0xFFFFFE -> branch_address=0xF8.
  - freeze=1 holds alu_res_mem and status across 3 clocks.
  - rst pulse mid-freeze clears all outputs immediately.
